// File: rtl/acq_search_ctrl_pkg.sv
// Shared types and default parameters for the acquisition search sequencer.
package acq_search_ctrl_pkg;

    // Sequencer states; IDLE and DONE are the only non-busy states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEEK  = 3'd1,
        ST_SLEW  = 3'd2,
        ST_DWELL = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } acq_state_t;

    localparam int ACQ_I2Q2_W    = 38;
    localparam int ACQ_CS_W      = 11;
    localparam int ACQ_DOPP_W    = 16;
    localparam int ACQ_CS_MAX    = 2045;
    localparam int ACQ_CS_STEP   = 1;
    localparam int ACQ_DOPP_BIN  = 64;
    localparam int ACQ_DOPP_ROWS = 7;
    localparam int ACQ_DWELL     = 2;
    localparam int ACQ_SLEW_TO   = 4096;

    // True while a search is in flight.
    function automatic logic acq_is_busy(input acq_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/acq_search_ctrl_peak.sv
// Peak tracker: keeps the strongest of prompt/early/late energies seen so far,
// with the code shift and Doppler that produced it. Ties keep the earlier winner.
module acq_peak_tracker
    import acq_search_ctrl_pkg::*;
#(
    parameter int I2Q2_W   = ACQ_I2Q2_W,
    parameter int CS_W     = ACQ_CS_W,
    parameter int DOPP_W   = ACQ_DOPP_W,
    parameter int DOPP_BIN = ACQ_DOPP_BIN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [I2Q2_W-1:0] early,
    input  logic [I2Q2_W-1:0] prompt,
    input  logic [I2Q2_W-1:0] late,
    input  logic [CS_W-1:0]   cs,
    input  logic [DOPP_W-1:0] doppler,
    output logic [I2Q2_W-1:0] best_i2q2,
    output logic [CS_W-1:0]   best_cs,
    output logic [DOPP_W-1:0] best_dopp
);

    logic [I2Q2_W-1:0] best_e_reg;
    logic [CS_W-1:0]   best_c_reg;
    logic [DOPP_W-1:0] best_d_reg;

    // Candidates in comparison order: prompt, early, late.
    logic [I2Q2_W-1:0] cand_e [3];
    logic [DOPP_W-1:0] cand_d [3];
    logic [I2Q2_W-1:0] run_e  [4];
    logic [DOPP_W-1:0] run_d  [4];
    logic              run_up [4];

    assign cand_e[0] = prompt;
    assign cand_d[0] = doppler;
    assign cand_e[1] = early;
    assign cand_d[1] = doppler + DOPP_W'(DOPP_BIN);
    assign cand_e[2] = late;
    assign cand_d[2] = doppler - DOPP_W'(DOPP_BIN);

    assign run_e[0]  = best_e_reg;
    assign run_d[0]  = best_d_reg;
    assign run_up[0] = 1'b0;

    // Chain of strictly-greater compares so earlier candidates win ties.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
            logic take;
            assign take         = cand_e[gi] > run_e[gi];
            assign run_e[gi+1]  = take ? cand_e[gi] : run_e[gi];
            assign run_d[gi+1]  = take ? cand_d[gi] : run_d[gi];
            assign run_up[gi+1] = run_up[gi] | take;
        end
    endgenerate

    // Register the winner one cycle after the result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_e_reg <= '0;
            best_c_reg <= '0;
            best_d_reg <= '0;
        end else if (clear) begin
            best_e_reg <= '0;
            best_c_reg <= '0;
            best_d_reg <= '0;
        end else if (in_valid && run_up[3]) begin
            best_e_reg <= run_e[3];
            best_c_reg <= cs;
            best_d_reg <= run_d[3];
        end
    end

    assign best_i2q2 = best_e_reg;
    assign best_cs   = best_c_reg;
    assign best_dopp = best_d_reg;

endmodule

// File: rtl/acq_search_ctrl.sv
// Acquisition search sequencer: walks code shift x Doppler rows for one PRN,
// slews the channel to each cell, dwells on its results and reports the peak.
module acq_search_ctrl
    import acq_search_ctrl_pkg::*;
#(
    parameter int I2Q2_W    = ACQ_I2Q2_W,
    parameter int CS_W      = ACQ_CS_W,
    parameter int DOPP_W    = ACQ_DOPP_W,
    parameter int CS_MAX    = ACQ_CS_MAX,
    parameter int CS_STEP   = ACQ_CS_STEP,
    parameter int DOPP_BIN  = ACQ_DOPP_BIN,
    parameter int DOPP_ROWS = ACQ_DOPP_ROWS,
    parameter int DWELL     = ACQ_DWELL,
    parameter int SLEW_TO   = ACQ_SLEW_TO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DOPP_W-1:0] dopp_start,
    input  logic [I2Q2_W-1:0] threshold,
    input  logic              early_exit,
    input  logic              i2q2_valid,
    input  logic [I2Q2_W-1:0] i2q2_early,
    input  logic [I2Q2_W-1:0] i2q2_prompt,
    input  logic [I2Q2_W-1:0] i2q2_late,
    input  logic [CS_W-1:0]   code_shift,
    output logic [DOPP_W-1:0] doppler,
    output logic              seek_en,
    output logic [CS_W-1:0]   seek_target,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              slew_err,
    output logic [I2Q2_W-1:0] best_i2q2,
    output logic [CS_W-1:0]   best_cs,
    output logic [DOPP_W-1:0] best_dopp
);

    localparam int DW_W  = $clog2(DWELL + 1);
    localparam int SL_W  = $clog2(SLEW_TO + 1);
    localparam int ROW_W = $clog2(DOPP_ROWS + 1);
    localparam logic [DOPP_W-1:0] ROW_STEP = DOPP_W'(3 * DOPP_BIN);

    acq_state_t        state_reg, state_next;
    logic [CS_W-1:0]   cs_reg, cs_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [DOPP_W-1:0] dopp_reg, dopp_next;
    logic [DW_W-1:0]   dwell_cnt_reg, dwell_cnt_next;
    logic [SL_W-1:0]   slew_cnt_reg, slew_cnt_next;
    logic              slew_err_reg, slew_err_next;
    logic              found_reg, found_next;
    logic              peak_clear, peak_valid;
    logic              hit;
    logic [CS_W:0]     cs_inc;
    logic [ROW_W-1:0]  row_inc;

    assign hit     = best_i2q2 >= threshold;
    assign cs_inc  = {1'b0, cs_reg} + (CS_W+1)'(CS_STEP);
    assign row_inc = row_reg + 1'b1;

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cs_reg        <= '0;
            row_reg       <= '0;
            dopp_reg      <= '0;
            dwell_cnt_reg <= '0;
            slew_cnt_reg  <= '0;
            slew_err_reg  <= 1'b0;
            found_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cs_reg        <= cs_next;
            row_reg       <= row_next;
            dopp_reg      <= dopp_next;
            dwell_cnt_reg <= dwell_cnt_next;
            slew_cnt_reg  <= slew_cnt_next;
            slew_err_reg  <= slew_err_next;
            found_reg     <= found_next;
        end
    end

    // Next-state logic; abort overrides everything including start.
    always_comb begin
        state_next     = state_reg;
        cs_next        = cs_reg;
        row_next       = row_reg;
        dopp_next      = dopp_reg;
        dwell_cnt_next = dwell_cnt_reg;
        slew_cnt_next  = slew_cnt_reg;
        slew_err_next  = slew_err_reg;
        found_next     = found_reg;
        peak_clear     = 1'b0;
        peak_valid     = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
            found_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        peak_clear    = 1'b1;
                        cs_next       = '0;
                        row_next      = '0;
                        dopp_next     = dopp_start;
                        slew_err_next = 1'b0;
                        found_next    = 1'b0;
                        state_next    = ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    slew_cnt_next = '0;
                    state_next    = ST_SLEW;
                end
                ST_SLEW: begin
                    if (code_shift == cs_reg) begin
                        dwell_cnt_next = '0;
                        state_next     = ST_DWELL;
                    end else if (slew_cnt_reg >= SL_W'(SLEW_TO - 1)) begin
                        slew_err_next = 1'b1;
                        state_next    = ST_NEXT;
                    end else begin
                        slew_cnt_next = slew_cnt_reg + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (i2q2_valid) begin
                        dwell_cnt_next = dwell_cnt_reg + 1'b1;
                        // First pulse of a cell covers a partial integration.
                        peak_valid     = (dwell_cnt_reg != '0);
                        if (dwell_cnt_reg == DW_W'(DWELL - 1)) begin
                            state_next = ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (early_exit && hit) begin
                        found_next = 1'b1;
                        state_next = ST_DONE;
                    end else if (cs_inc > (CS_W+1)'(CS_MAX)) begin
                        cs_next   = '0;
                        row_next  = row_inc;
                        dopp_next = dopp_reg + ROW_STEP;
                        if (row_inc == ROW_W'(DOPP_ROWS)) begin
                            found_next = hit;
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_SEEK;
                        end
                    end else begin
                        cs_next    = cs_inc[CS_W-1:0];
                        state_next = ST_SEEK;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    acq_peak_tracker #(
        .I2Q2_W   (I2Q2_W),
        .CS_W     (CS_W),
        .DOPP_W   (DOPP_W),
        .DOPP_BIN (DOPP_BIN)
    ) u_peak (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (peak_clear),
        .in_valid  (peak_valid),
        .early     (i2q2_early),
        .prompt    (i2q2_prompt),
        .late      (i2q2_late),
        .cs        (cs_reg),
        .doppler   (dopp_reg),
        .best_i2q2 (best_i2q2),
        .best_cs   (best_cs),
        .best_dopp (best_dopp)
    );

    assign doppler     = dopp_reg;
    assign seek_en     = (state_reg == ST_SEEK);
    assign seek_target = cs_reg;
    assign busy        = acq_is_busy(state_reg);
    assign done        = (state_reg == ST_DONE);
    assign found       = found_reg;
    assign slew_err    = slew_err_reg;

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Directed bench for acq_search_ctrl on a small 4x2 grid with a behavioural channel.
module tb_acq_search_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] dopp_start;
    logic [37:0] threshold;
    logic        early_exit;
    logic        i2q2_valid;
    logic [37:0] i2q2_early;
    logic [37:0] i2q2_prompt;
    logic [37:0] i2q2_late;
    logic [10:0] code_shift;
    logic [15:0] doppler;
    logic        seek_en;
    logic [10:0] seek_target;
    logic        busy;
    logic        done;
    logic        found;
    logic        slew_err;
    logic [37:0] best_i2q2;
    logic [10:0] best_cs;
    logic [15:0] best_dopp;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    int seek_cnt = 0;
    int n_seek;
    int base;

    acq_search_ctrl #(
        .CS_MAX    (3),
        .DOPP_ROWS (2),
        .DWELL     (2),
        .SLEW_TO   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .dopp_start  (dopp_start),
        .threshold   (threshold),
        .early_exit  (early_exit),
        .i2q2_valid  (i2q2_valid),
        .i2q2_early  (i2q2_early),
        .i2q2_prompt (i2q2_prompt),
        .i2q2_late   (i2q2_late),
        .code_shift  (code_shift),
        .doppler     (doppler),
        .seek_en     (seek_en),
        .seek_target (seek_target),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .slew_err    (slew_err),
        .best_i2q2   (best_i2q2),
        .best_cs     (best_cs),
        .best_dopp   (best_dopp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Channel energies per test mode: pn is pulse number in the cell (1 or 2).
    task automatic drive_pulse(input int m, input int pn, input logic [10:0] c, input int r);
        logic [37:0] p, e, l;
        p = 38'd10; e = 38'd10; l = 38'd10;
        case (m)
            0: if (c == 11'd2 && r == 1) p = 38'd500;
            1: if (c == 11'd1 && r == 0) begin p = 38'd300; e = 38'd300; l = 38'd300; end
            2: if (c == 11'd1 && r == 0) begin p = 38'd300; e = 38'd300; l = 38'd301; end
            3: begin p = (pn == 1) ? 38'd9999 : 38'd5; e = 38'd0; l = 38'd0; end
            4: if (c == 11'd1 && r == 0) p = 38'd150;
            default: ;
        endcase
        i2q2_prompt = p;
        i2q2_early  = e;
        i2q2_late   = l;
        i2q2_valid  = 1'b1;
    endtask

    // Behavioural channel: slews two cycles after a seek, then emits two result pulses.
    initial begin
        logic [10:0] tgt;
        int rw;
        code_shift  = '0;
        i2q2_valid  = 1'b0;
        i2q2_early  = '0;
        i2q2_prompt = '0;
        i2q2_late   = '0;
        forever begin
            @(negedge clk);
            if (seek_en) begin
                seek_cnt++;
                tgt = seek_target;
                rw  = int'(16'(doppler - dopp_start)) / 192;
                @(negedge clk);
                @(negedge clk);
                if (mode == 5) begin
                    code_shift = tgt + 11'd100;
                end else begin
                    code_shift = tgt;
                    @(negedge clk);
                    drive_pulse(mode, 1, tgt, rw);
                    @(negedge clk);
                    i2q2_valid = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                    drive_pulse(mode, 2, tgt, rw);
                    @(negedge clk);
                    i2q2_valid = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start one search and wait (bounded) for done; optionally pulse start mid-run.
    task automatic run_search(input int m, input logic [15:0] ds, input logic [37:0] thr,
                              input logic ee, input logic inject, output int seeks);
        int b;
        logic got;
        mode       = m;
        dopp_start = ds;
        threshold  = thr;
        early_exit = ee;
        b = seek_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            start = (inject && i == 30);
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("done_m%0d", m), 64'(got), 64'd1);
        idle(20);
        seeks = seek_cnt - b;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        dopp_start = '0;
        threshold  = '0;
        early_exit = 1'b0;
        idle(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_seek_en", 64'(seek_en), 64'd0);
        check("rst_doppler", 64'(doppler), 64'd0);
        check("rst_best", 64'(best_i2q2), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // start and abort together: abort wins
        base  = seek_cnt;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        idle(3);
        check("startabort_busy", 64'(busy), 64'd0);
        check("startabort_seeks", 64'(seek_cnt - base), 64'd0);

        // full grid, extra start mid-run must be ignored
        run_search(0, 16'h0100, 38'd400, 1'b0, 1'b1, n_seek);
        check("grid_seeks", 64'(n_seek), 64'd8);
        check("grid_best", 64'(best_i2q2), 64'd500);
        check("grid_cs", 64'(best_cs), 64'd2);
        check("grid_dopp", 64'(best_dopp), 64'h01C0);
        check("grid_found", 64'(found), 64'd1);
        check("grid_slew_err", 64'(slew_err), 64'd0);

        // ties: equal energies keep prompt; larger late wins and wraps below zero
        run_search(1, 16'h0010, 38'd1000, 1'b0, 1'b0, n_seek);
        check("tie_dopp", 64'(best_dopp), 64'h0010);
        check("tie_cs", 64'(best_cs), 64'd1);
        check("tie_found", 64'(found), 64'd0);
        run_search(2, 16'h0010, 38'd1000, 1'b0, 1'b0, n_seek);
        check("late_dopp", 64'(best_dopp), 64'hFFD0);
        check("late_best", 64'(best_i2q2), 64'd301);

        // first pulse of each cell is discarded
        run_search(3, 16'h0200, 38'd1000, 1'b0, 1'b0, n_seek);
        check("discard_best", 64'(best_i2q2), 64'd5);
        check("discard_cs", 64'(best_cs), 64'd0);
        check("discard_dopp", 64'(best_dopp), 64'h0200);

        // early exit after the cell with energy 150
        run_search(4, 16'h0000, 38'd100, 1'b1, 1'b0, n_seek);
        check("ee_seeks", 64'(n_seek), 64'd2);
        check("ee_found", 64'(found), 64'd1);
        check("ee_cs", 64'(best_cs), 64'd1);
        check("ee_best", 64'(best_i2q2), 64'd150);

        // channel never reaches target: every cell times out
        run_search(5, 16'h0000, 38'd1, 1'b0, 1'b0, n_seek);
        check("stuck_slew_err", 64'(slew_err), 64'd1);
        check("stuck_seeks", 64'(n_seek), 64'd8);
        check("stuck_best", 64'(best_i2q2), 64'd0);
        check("stuck_found", 64'(found), 64'd0);

        // next start clears the sticky slew error
        run_search(0, 16'h0100, 38'd400, 1'b0, 1'b0, n_seek);
        check("restart_slew_err", 64'(slew_err), 64'd0);
        check("restart_best", 64'(best_i2q2), 64'd500);

        // abort mid-run
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(25);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        idle(20);
        base = seek_cnt;
        idle(20);
        check("abort_no_seek", 64'(seek_cnt - base), 64'd0);

        // reset pulse in the middle of a dwell
        dopp_start = 16'h0100;
        base  = seek_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (seek_cnt - base >= 3) break;
            @(negedge clk);
        end
        check("mid_reached_cell2", 64'(seek_cnt - base >= 3), 64'd1);
        idle(4);
        check("mid_pre_best", 64'(best_i2q2), 64'd10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_best", 64'(best_i2q2), 64'd0);
        check("mid_rst_doppler", 64'(doppler), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        base = seek_cnt;
        idle(30);
        check("mid_rst_no_seek", 64'(seek_cnt - base), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
